// File: rtl/power_meter_pkg.sv
// rtl/power_meter_pkg.sv - shared constants and width helpers for the power meter
package power_meter_pkg;

   localparam logic MODE_BLOCK   = 1'b0;
   localparam logic MODE_SLIDING = 1'b1;
   localparam int   MAX_LOG2_N   = 12;

   // I^2 + Q^2 of two signed sw-bit samples needs one bit beyond a single square
   function automatic int pow_width(input int sw);
      return 2 * sw + 1;
   endfunction

   function automatic int acc_width(input int sw, input int log2_n);
      return 2 * sw + 1 + log2_n;
   endfunction

endpackage

// File: rtl/pipe_mult.sv
// rtl/pipe_mult.sv - signed multiplier with a configurable, enable-gated output pipeline
module pipe_mult #(
   parameter int WIDTH = 16,
   parameter int PIPE  = 4
) (
   input  logic                        clk,
   input  logic                        en,
   input  logic signed [WIDTH-1:0]     a,
   input  logic signed [WIDTH-1:0]     b,
   output logic signed [2*WIDTH-1:0]   p
);

   logic signed [2*WIDTH-1:0] stage [PIPE];

   always_ff @(posedge clk) begin
      if (en) begin
         stage[0] <= a * b;
         for (int k = 1; k < PIPE; k++) begin
            stage[k] <= stage[k-1];
         end
      end
   end

   assign p = stage[PIPE-1];

endmodule

// File: rtl/power_history_ram.sv
// rtl/power_history_ram.sv - simple dual-port product history, one-cycle registered read
module power_history_ram #(
   parameter int ADDR_W = 9,
   parameter int DATA_W = 33
) (
   input  logic              clk,
   input  logic              en,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [DATA_W-1:0] rd_data
);

   logic [DATA_W-1:0] mem [1 << ADDR_W];

   always_ff @(posedge clk) begin
      if (en) begin
         if (wr_en) begin
            mem[wr_addr] <= wr_data;
         end
         rd_data <= mem[rd_addr];
      end
   end

endmodule

// File: rtl/power_meter.sv
// rtl/power_meter.sv - I/Q average power estimator, block or sliding window
// Optional peak hold enabled by defining POWER_METER_PEAK_EN.
module power_meter
   import power_meter_pkg::*;
#(
   parameter int SYMBOL_WIDTH = 16,
   parameter int LOG2_N       = 9,
   parameter int MULT_PIPE    = 4
) (
   input  logic                                   clk,
   input  logic                                   rst,
   input  logic                                   en,
   input  logic                                   mode,
   input  logic                                   new_sample,
   input  logic signed [SYMBOL_WIDTH-1:0]         sample_i,
   input  logic signed [SYMBOL_WIDTH-1:0]         sample_q,
   input  logic [pow_width(SYMBOL_WIDTH)-1:0]     threshold,
   output logic                                   new_estimate,
   output logic [pow_width(SYMBOL_WIDTH)-1:0]     average_power,
   output logic                                   above_threshold,
`ifdef POWER_METER_PEAK_EN
   input  logic                                   peak_clear,
   output logic [pow_width(SYMBOL_WIDTH)-1:0]     peak_power,
`endif
   output logic                                   window_full
);

   localparam int PW = pow_width(SYMBOL_WIDTH);
   localparam int AW = acc_width(SYMBOL_WIDTH, LOG2_N);

   logic signed [2*SYMBOL_WIDTH-1:0] sq_i, sq_q;
   logic [PW-1:0]        power_c, p_reg, old_p, avg_c;
   logic [MULT_PIPE-1:0] vld;
   logic                 p_vld, est_pend, mode_q, mode_chg, last, fire, wr_en;
   logic [LOG2_N-1:0]    cnt, ptr, rd_addr;
   logic [AW-1:0]        acc, est_sum, sum_add, sum_next;

   pipe_mult #(.WIDTH(SYMBOL_WIDTH), .PIPE(MULT_PIPE)) u_mult_i (
      .clk(clk), .en(en), .a(sample_i), .b(sample_i), .p(sq_i)
   );

   pipe_mult #(.WIDTH(SYMBOL_WIDTH), .PIPE(MULT_PIPE)) u_mult_q (
      .clk(clk), .en(en), .a(sample_q), .b(sample_q), .p(sq_q)
   );

   // Read the slot this product will overwrite: the pointer after the product ahead of it advances
   power_history_ram #(.ADDR_W(LOG2_N), .DATA_W(PW)) u_hist (
      .clk(clk), .en(en), .wr_en(wr_en), .wr_addr(ptr), .wr_data(p_reg),
      .rd_addr(rd_addr), .rd_data(old_p)
   );

   always_comb begin
      power_c  = PW'($unsigned(sq_i)) + PW'($unsigned(sq_q));
      mode_chg = (mode != mode_q);
      rd_addr  = ptr + LOG2_N'(p_vld);
      last     = (cnt == {LOG2_N{1'b1}});
      sum_add  = acc + AW'(p_reg);
      sum_next = sum_add;
      if (mode_q == MODE_SLIDING && window_full) begin
         sum_next = sum_add - AW'(old_p);
      end
      fire  = p_vld && ((mode_q == MODE_BLOCK) ? last : (window_full || last));
      wr_en = p_vld && (mode_q == MODE_SLIDING) && !mode_chg;
      avg_c = est_sum[AW-1:LOG2_N];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         mode_q          <= mode;
         vld             <= '0;
         p_vld           <= 1'b0;
         p_reg           <= '0;
         cnt             <= '0;
         ptr             <= '0;
         acc             <= '0;
         est_sum         <= '0;
         est_pend        <= 1'b0;
         window_full     <= 1'b0;
         new_estimate    <= 1'b0;
         average_power   <= '0;
         above_threshold <= 1'b0;
      end else if (en) begin
         mode_q <= mode;
         p_reg  <= power_c;
         if (mode_chg) begin
            // The sample arriving with the mode change belongs to the new mode
            vld          <= MULT_PIPE'(new_sample);
            p_vld        <= 1'b0;
            cnt          <= '0;
            ptr          <= '0;
            acc          <= '0;
            est_pend     <= 1'b0;
            window_full  <= 1'b0;
            new_estimate <= 1'b0;
         end else begin
            vld          <= (vld << 1) | MULT_PIPE'(new_sample);
            p_vld        <= vld[MULT_PIPE-1];
            est_pend     <= fire;
            new_estimate <= est_pend;
            if (est_pend) begin
               average_power   <= avg_c;
               above_threshold <= (avg_c >= threshold);
            end
            if (p_vld) begin
               cnt <= cnt + 1'b1;
               if (mode_q == MODE_SLIDING) begin
                  ptr <= ptr + 1'b1;
               end
               if (last) begin
                  window_full <= 1'b1;
               end
               acc <= (mode_q == MODE_BLOCK && last) ? '0 : sum_next;
               if (fire) begin
                  est_sum <= sum_next;
               end
            end
         end
      end
   end

`ifdef POWER_METER_PEAK_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         peak_power <= '0;
      end else if (en) begin
         if (new_estimate && (peak_clear || average_power > peak_power)) begin
            peak_power <= average_power;
         end else if (peak_clear) begin
            peak_power <= '0;
         end
      end
   end
`endif

endmodule

// File: tb/tb_power_meter.sv
// tb/tb_power_meter.sv - directed self-checking bench for power_meter
module tb_power_meter;

   localparam int SW = 16;
   localparam int L2N = 2;
   localparam int MP = 4;
   localparam int PW = 2 * SW + 1;

   logic clk = 1'b0;
   logic rst, en, mode, new_sample;
   logic signed [SW-1:0] sample_i, sample_q;
   logic [PW-1:0] threshold, average_power;
   logic new_estimate, above_threshold, window_full;
`ifdef POWER_METER_PEAK_EN
   logic peak_clear;
   logic [PW-1:0] peak_power;
`endif

   int vectors = 0;
   int errors = 0;
   int cyc = 0;
   int pc[$];
   int sc[$];
   logic [PW-1:0] pv[$];

   always #5 clk = ~clk;

   power_meter #(.SYMBOL_WIDTH(SW), .LOG2_N(L2N), .MULT_PIPE(MP)) dut (
      .clk(clk), .rst(rst), .en(en), .mode(mode), .new_sample(new_sample),
      .sample_i(sample_i), .sample_q(sample_q), .threshold(threshold),
      .new_estimate(new_estimate), .average_power(average_power),
      .above_threshold(above_threshold),
`ifdef POWER_METER_PEAK_EN
      .peak_clear(peak_clear), .peak_power(peak_power),
`endif
      .window_full(window_full)
   );

   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
      if (new_estimate === 1'b1) begin
         pc.push_back(cyc);
         pv.push_back(average_power);
      end
   endtask

   task automatic send(input logic signed [SW-1:0] i, input logic signed [SW-1:0] q);
      sample_i = i;
      sample_q = q;
      sc.push_back(cyc);
      new_sample = 1'b1;
      tick();
      new_sample = 1'b0;
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) tick();
   endtask

   task automatic clear_log();
      pc.delete();
      sc.delete();
      pv.delete();
   endtask

   task automatic do_reset(input logic m);
      mode = m;
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      clear_log();
   endtask

   task automatic test_reset();
      do_reset(1'b0);
      vectors++; if (new_estimate !== 1'b0) begin errors++; $display("FAIL reset_new_estimate got %0b want 0", new_estimate); end
      vectors++; if (average_power !== '0) begin errors++; $display("FAIL reset_average_power got %h want 0", average_power); end
      vectors++; if (above_threshold !== 1'b0) begin errors++; $display("FAIL reset_above got %0b want 0", above_threshold); end
      vectors++; if (window_full !== 1'b0) begin errors++; $display("FAIL reset_window_full got %0b want 0", window_full); end
   endtask

   task automatic test_back_to_back();
      do_reset(1'b0);
      threshold = 33'h020000000;
      for (int k = 0; k < 8; k++) send(16'sh4000, 16'sh4000);
      idle(12);
      vectors++; if (pc.size() != 2) begin errors++; $display("FAIL b2b_pulses got %0d want 2", pc.size()); end
      vectors++; if (pv.size() < 1 || pv[0] !== 33'h020000000) begin errors++; $display("FAIL b2b_avg0 got %h want 020000000", pv.size() ? pv[0] : 'x); end
      vectors++; if (pv.size() < 2 || pv[1] !== 33'h020000000) begin errors++; $display("FAIL b2b_avg1 got %h want 020000000", pv.size() > 1 ? pv[1] : 'x); end
      vectors++; if (pc.size() < 1 || pc[0] - sc[3] != 7) begin errors++; $display("FAIL b2b_latency0 got %0d want 7", pc.size() ? pc[0] - sc[3] : -1); end
      vectors++; if (pc.size() < 2 || pc[1] - sc[7] != 7) begin errors++; $display("FAIL b2b_latency1 got %0d want 7", pc.size() > 1 ? pc[1] - sc[7] : -1); end
      vectors++; if (above_threshold !== 1'b1) begin errors++; $display("FAIL b2b_above got %0b want 1", above_threshold); end
      vectors++; if (window_full !== 1'b1) begin errors++; $display("FAIL b2b_window_full got %0b want 1", window_full); end
   endtask

   task automatic test_full_scale();
      do_reset(1'b0);
      for (int k = 0; k < 4; k++) send(16'sh8000, 16'sh8000);
      idle(10);
      vectors++; if (pc.size() != 1) begin errors++; $display("FAIL max_pulses got %0d want 1", pc.size()); end
      vectors++; if (average_power !== 33'h080000000) begin errors++; $display("FAIL max_avg got %h want 080000000", average_power); end
   endtask

   task automatic test_threshold_below();
      do_reset(1'b0);
      threshold = 33'h020000000;
      for (int k = 0; k < 4; k++) send(16'sh3FFF, 16'sh3FFF);
      idle(10);
      vectors++; if (average_power !== 33'h01FFF0002) begin errors++; $display("FAIL below_avg got %h want 01fff0002", average_power); end
      vectors++; if (above_threshold !== 1'b0) begin errors++; $display("FAIL below_above got %0b want 0", above_threshold); end
   endtask

   task automatic test_sliding();
      do_reset(1'b1);
      for (int k = 1; k <= 5; k++) send(SW'(k), 16'sd0);
      idle(10);
      vectors++; if (pc.size() != 2) begin errors++; $display("FAIL slide_pulses got %0d want 2", pc.size()); end
      vectors++; if (pv.size() < 1 || pv[0] !== 33'd7) begin errors++; $display("FAIL slide_avg0 got %0d want 7", pv.size() ? pv[0] : 'x); end
      vectors++; if (pv.size() < 2 || pv[1] !== 33'd13) begin errors++; $display("FAIL slide_avg1 got %0d want 13", pv.size() > 1 ? pv[1] : 'x); end
      vectors++; if (pc.size() < 1 || pc[0] - sc[3] != 7) begin errors++; $display("FAIL slide_latency got %0d want 7", pc.size() ? pc[0] - sc[3] : -1); end
   endtask

   task automatic test_reset_in_flight();
      do_reset(1'b0);
      send(16'sh4000, 16'sd0);
      send(16'sh4000, 16'sd0);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      clear_log();
      for (int k = 0; k < 4; k++) send(16'sh4000, 16'sd0);
      idle(10);
      vectors++; if (pc.size() != 1) begin errors++; $display("FAIL rstmid_pulses got %0d want 1", pc.size()); end
      vectors++; if (average_power !== 33'h010000000) begin errors++; $display("FAIL rstmid_avg got %h want 010000000", average_power); end
      vectors++; if (pc.size() < 1 || pc[0] - sc[3] != 7) begin errors++; $display("FAIL rstmid_latency got %0d want 7", pc.size() ? pc[0] - sc[3] : -1); end
   endtask

   task automatic test_mode_toggle();
      do_reset(1'b0);
      threshold = 33'h010000000;
      for (int k = 0; k < 4; k++) send(16'sh4000, 16'sh4000);
      idle(10);
      clear_log();
      for (int k = 0; k < 3; k++) send(16'sh1000, 16'sd0);
      mode = 1'b1;
      idle(12);
      vectors++; if (pc.size() != 0) begin errors++; $display("FAIL toggle_pulses got %0d want 0", pc.size()); end
      vectors++; if (window_full !== 1'b0) begin errors++; $display("FAIL toggle_window_full got %0b want 0", window_full); end
      vectors++; if (average_power !== 33'h020000000) begin errors++; $display("FAIL toggle_avg_held got %h want 020000000", average_power); end
      vectors++; if (above_threshold !== 1'b1) begin errors++; $display("FAIL toggle_above_held got %0b want 1", above_threshold); end
      mode = 1'b0;
      idle(2);
      clear_log();
      for (int k = 0; k < 4; k++) send(16'sh2000, 16'sd0);
      idle(10);
      vectors++; if (pc.size() != 1) begin errors++; $display("FAIL toggle_restart_pulses got %0d want 1", pc.size()); end
      vectors++; if (average_power !== 33'h004000000) begin errors++; $display("FAIL toggle_restart_avg got %h want 004000000", average_power); end
      vectors++; if (pc.size() < 1 || pc[0] - sc[3] != 7) begin errors++; $display("FAIL toggle_restart_latency got %0d want 7", pc.size() ? pc[0] - sc[3] : -1); end
   endtask

   task automatic test_enable_stall();
      do_reset(1'b0);
      for (int k = 0; k < 4; k++) send(16'sh0100, 16'sh0100);
      en = 1'b0;
      idle(5);
      en = 1'b1;
      idle(10);
      vectors++; if (pc.size() < 1 || pc[0] - sc[3] != 12) begin errors++; $display("FAIL stall_latency got %0d want 12", pc.size() ? pc[0] - sc[3] : -1); end
      vectors++; if (average_power !== 33'h000020000) begin errors++; $display("FAIL stall_avg got %h want 000020000", average_power); end
   endtask

   initial begin
      rst = 1'b1;
      en = 1'b1;
      mode = 1'b0;
      new_sample = 1'b0;
      sample_i = '0;
      sample_q = '0;
      threshold = '0;
`ifdef POWER_METER_PEAK_EN
      peak_clear = 1'b0;
`endif
      test_reset();
      test_back_to_back();
      test_full_scale();
      test_threshold_below();
      test_sliding();
      test_reset_in_flight();
      test_mode_toggle();
      test_enable_stall();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
